// File: rtl/buffer_rr_arbiter.sv
// buffer_rr_arbiter
//   Round-robin arbiter that shares one registered WIDTH-bit buffer stage
//   between NUM_REQ requesters. Each accepted beat grants exactly one
//   requester and captures its word into the output register. The word is
//   presented downstream with valid/ready and the index of its source.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   req_valid   [NUM_REQ]        requester i has a word
//   req_data    [NUM_REQ*WIDTH]  word of requester i at [i*WIDTH +: WIDTH]
//   req_ready   [NUM_REQ]        one-hot, word of requester i captured this cycle
//   out_valid   output register holds a word
//   out_data    [WIDTH]          registered word
//   out_src     [SRC_W]          requester index that supplied out_data
//   out_ready   downstream accepts out_data this cycle
//   xfer_count  [CNT_W]          downstream-accepted beats, wraps to 0
//
// Configuration macro
//   BUF_ARB_PRIO0_EN : requester 0 gets absolute priority and does not move
//                      the round-robin pointer; others rotate among themselves.

module buffer_rr_arbiter #(
  parameter  int WIDTH   = 32,
  parameter  int NUM_REQ = 4,
  parameter  int CNT_W   = 16,
  localparam int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [SRC_W-1:0]         out_src,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         xfer_count
);

  localparam int unsigned NREQ_U = NUM_REQ;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [SRC_W-1:0] rr_ptr, rr_nxt, grant_idx;
  logic             grant_found;
  logic             load_ok, capture, advance;

  // Grant search: first valid requester starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned idx;
    grant_idx   = '0;
    grant_found = 1'b0;
    idx         = 0;
`ifdef BUF_ARB_PRIO0_EN
    if (req_valid[0]) begin
      grant_found = 1'b1;
      grant_idx   = '0;
    end
`endif
    for (int unsigned k = 0; k < NREQ_U; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NREQ_U) idx = idx - NREQ_U;
      if (!grant_found && req_valid[SRC_W'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = SRC_W'(idx);
      end
    end
  end

  // Explicit wrap keeps the pointer legal for non-power-of-2 NUM_REQ.
  always_comb begin
    rr_nxt = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    out_valid = (state == BUSY);
    load_ok   = (state == IDLE) || out_ready;
    // Gating with reset keeps req_ready low while reset is held, since the
    // FSM sits in IDLE (where load_ok is true) during reset.
    capture   = load_ok && grant_found && !reset;
`ifdef BUF_ARB_PRIO0_EN
    advance   = capture && (grant_idx != '0);
`else
    advance   = capture;
`endif
    if (capture) req_ready[grant_idx] = 1'b1;
    case (state)
      IDLE: if (capture) state_nxt = BUSY;
      BUSY: begin
        if (capture)        state_nxt = BUSY;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      out_data   <= '0;
      out_src    <= '0;
      xfer_count <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        out_data <= req_data[grant_idx*WIDTH +: WIDTH];
        out_src  <= grant_idx;
      end
      if (advance) rr_ptr <= rr_nxt;
      if (out_valid && out_ready) xfer_count <= xfer_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_buffer_rr_arbiter.sv
// tb_buffer_rr_arbiter
//   Directed bench for buffer_rr_arbiter (NUM_REQ=4, WIDTH=32). A second
//   instance with CNT_W=4 shares the stimulus to exercise counter wrap.
//   Expected grants and words come from a reference round-robin model and
//   are queued at handshake, then compared when the word appears downstream.

module tb_buffer_rr_arbiter;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic           out_ready;

  logic [N-1:0]   req_ready,  req_ready4;
  logic           out_valid,  out_valid4;
  logic [W-1:0]   out_data,   out_data4;
  logic [1:0]     out_src,    out_src4;
  logic [15:0]    xfer_count;
  logic [3:0]     xfer_count4;

  always #5 clk = ~clk;

  buffer_rr_arbiter #(.WIDTH(W), .NUM_REQ(N), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready), .xfer_count(xfer_count)
  );

  buffer_rr_arbiter #(.WIDTH(W), .NUM_REQ(N), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready4), .out_valid(out_valid4), .out_data(out_data4),
    .out_src(out_src4), .out_ready(out_ready), .xfer_count(xfer_count4)
  );

  typedef struct {
    logic [1:0]   src;
    logic [W-1:0] data;
  } beat_t;

  beat_t        sb[$];
  int           errors = 0;
  int           checks = 0;
  int           m_rr, m_cnt;
  bit           m_busy;
  bit           fix_data;
  logic [W-1:0] words [N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] v);
    if (v == '0) return -1;
`ifdef BUF_ARB_PRIO0_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      if (v[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    req_valid = '1;
    out_ready = 1'b1;
    reset     = 1'b1;
    #1;
    check("rst_out_valid",  out_valid,   0);
    check("rst_req_ready",  req_ready,   0);
    check("rst_out_src",    out_src,     0);
    check("rst_out_data",   out_data,    0);
    check("rst_xfer_count", xfer_count,  0);
    check("rst_xfer_w4",    xfer_count4, 0);
    sb.delete();
    m_rr   = 0;
    m_cnt  = 0;
    m_busy = 1'b0;
    @(negedge clk);
    check("rst_hold_req_ready", req_ready, 0);
    reset     = 1'b0;
    req_valid = '0;
  endtask

  // One clock cycle: check registered outputs, drive new inputs, check the
  // combinational grant, then advance the model to the next edge.
  task automatic cycle(input logic [N-1:0] v, input logic ordy);
    int         g;
    logic [N-1:0] exp_rdy;
    beat_t      b;
    @(negedge clk);
    #1;
    check("out_valid",   out_valid,   m_busy);
    check("xfer_count",  xfer_count,  64'(m_cnt % 65536));
    check("xfer_w4",     xfer_count4, 64'(m_cnt % 16));
    if (m_busy) begin
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL scoreboard: observed=empty expected=pending beat");
      end else begin
        b = sb[0];
        check("out_data", out_data, b.data);
        check("out_src",  out_src,  b.src);
      end
    end
    if (!fix_data) begin
      for (int i = 0; i < N; i++) words[i] = $urandom;
    end
    for (int i = 0; i < N; i++) req_data[i*W +: W] = words[i];
    req_valid = v;
    out_ready = ordy;
    #1;
    g = -1;
    if (!m_busy || ordy) g = model_grant(v);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    if (m_busy && ordy) begin
      m_cnt++;
      if (sb.size() != 0) void'(sb.pop_front());
    end
    if (g >= 0) begin
      sb.push_back('{2'(g), words[g]});
`ifdef BUF_ARB_PRIO0_EN
      if (g != 0) m_rr = (g + 1) % N;
`else
      m_rr = (g + 1) % N;
`endif
    end
    m_busy = (g >= 0) || (m_busy && !ordy);
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    fix_data  = 1'b0;
    for (int i = 0; i < N; i++) words[i] = '0;

    // Reset with all requesters active
    do_reset();

    // Single requester 2, fixed word, one-cycle latency
    fix_data = 1'b1;
    words[0] = 32'h0; words[1] = 32'h0; words[2] = 32'hDEADBEEF; words[3] = 32'h0;
    cycle(4'b0100, 1'b1);
    fix_data = 1'b0;
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);

    // All requesting, back-to-back rotation 0,1,2,3,0,1
    do_reset();
    repeat (6) cycle(4'b1111, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);

    // Stall three cycles while busy, then resume at next rr index
    cycle(4'b1111, 1'b1);
    cycle(4'b1111, 1'b1);
    repeat (3) cycle(4'b1111, 1'b0);
    cycle(4'b1111, 1'b1);
    cycle(4'b1111, 1'b1);

    // Requests stop, output drains, then lone requester 1 from IDLE
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b0010, 1'b0);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b0);

    // Priority-0 sequence (model follows build configuration)
    do_reset();
    repeat (4) cycle(4'b1111, 1'b1);
    repeat (4) cycle(4'b1110, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);

    // Reset asserted while busy and stalled
    cycle(4'b1111, 1'b1);
    cycle(4'b1111, 1'b0);
    do_reset();

    // Random traffic, then a long burst to wrap the 4-bit counter
    repeat (24) cycle(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    repeat (20) cycle(4'b1111, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
